// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/note-off events onto VOICES synth
// voices with age-ordered stealing, same-note retrigger, velocity-0 note-off
// and sustain-pedal hold. All outputs are registered (one cycle after the
// accepting edge).
//
// Event strobe: an event is taken on a rising CLK edge when
// CE & HANDLE_NOTE & (NOTE_ON | NOTE_OFF); there is no back-pressure, so the
// source may present one event per enabled cycle.
module voice_alloc #(
  parameter int VOICES = 8,
  parameter int NUM_W  = 7,
  parameter int VEL_W  = 7,
  parameter int STEAL  = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic [NUM_W-1:0]          NOTE_NUM,
  input  logic [VEL_W-1:0]          NOTE_VEL,
  input  logic                      HANDLE_NOTE,
  input  logic                      NOTE_ON,
  input  logic                      NOTE_OFF,
  input  logic                      SUSTAIN,
  output logic [VOICES*NUM_W-1:0]   VOICE_NUM,
  output logic [VOICES*VEL_W-1:0]   VOICE_VEL,
  output logic [VOICES-1:0]         VOICE_GATE,
  output logic [VOICES-1:0]         VOICE_TRIG,
  output logic [$clog2(VOICES):0]   ACTIVE_CNT,
  output logic                      STOLEN,
  output logic                      DROPPED
);

  localparam int AGE_W = $clog2(VOICES);
  localparam int CNT_W = AGE_W + 1;

  // Per-voice state
  logic [VOICES-1:0] gate_q, gate_d;
  logic [VOICES-1:0] held_q, held_d;
  logic [VOICES-1:0] trig_q, trig_d;
  logic [NUM_W-1:0]  num_q [VOICES];
  logic [NUM_W-1:0]  num_d [VOICES];
  logic [VEL_W-1:0]  vel_q [VOICES];
  logic [VEL_W-1:0]  vel_d [VOICES];
  logic [AGE_W-1:0]  age_q [VOICES];
  logic [AGE_W-1:0]  age_d [VOICES];

  // Global state
  logic             sus_q, sus_d;
  logic             stolen_q, stolen_d;
  logic             dropped_q, dropped_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Event decode
  logic accept, is_on, is_off, pedal_rel;

  // Search results (all taken from the pre-edge voice state)
  logic             hit_found, free_found, off_found;
  logic [AGE_W-1:0] hit_idx, free_idx, off_idx, old_idx;

  // Voice to (re)start this edge
  logic             start_en;
  logic [AGE_W-1:0] start_idx;

  // Classify the incoming event; velocity 0 or both flags set means release
  always_comb begin
    accept    = CE & HANDLE_NOTE & (NOTE_ON | NOTE_OFF);
    is_on     = accept & NOTE_ON & ~NOTE_OFF & (NOTE_VEL != '0);
    is_off    = accept & ~is_on;
    pedal_rel = CE & sus_q & ~SUSTAIN;
  end

  // Lowest-index searches: descending loop so the lowest match is written last
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    off_found  = 1'b0;
    off_idx    = '0;
    old_idx    = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && (num_q[i] == NOTE_NUM)) begin
        hit_found = 1'b1;
        hit_idx   = AGE_W'(i);
      end
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = AGE_W'(i);
      end
      if (gate_q[i] && !held_q[i] && (num_q[i] == NOTE_NUM)) begin
        off_found = 1'b1;
        off_idx   = AGE_W'(i);
      end
      if (age_q[i] == AGE_W'(VOICES - 1)) begin
        old_idx = AGE_W'(i);
      end
    end
  end

  // Note-on priority: retrigger, then free voice, then steal or drop
  always_comb begin
    start_en  = 1'b0;
    start_idx = hit_idx;
    stolen_d  = 1'b0;
    dropped_d = 1'b0;
    if (is_on) begin
      if (hit_found) begin
        start_en = 1'b1;
      end else if (free_found) begin
        start_en  = 1'b1;
        start_idx = free_idx;
      end else if (STEAL != 0) begin
        start_en  = 1'b1;
        start_idx = old_idx;
        stolen_d  = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  // Next voice state: pedal release first, the event then overrides its voice
  always_comb begin
    gate_d = gate_q;
    held_d = held_q;
    num_d  = num_q;
    vel_d  = vel_q;
    age_d  = age_q;
    trig_d = '0;
    sus_d  = sus_q;
    cnt_d  = '0;
    if (CE) begin
      sus_d = SUSTAIN;
    end
    if (pedal_rel) begin
      for (int i = 0; i < VOICES; i++) begin
        if (held_q[i]) begin
          gate_d[i] = 1'b0;
          held_d[i] = 1'b0;
          vel_d[i]  = '0;
        end
      end
    end
    if (start_en) begin
      for (int i = 0; i < VOICES; i++) begin
        if (age_q[i] < age_q[start_idx]) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
      age_d[start_idx]  = '0;
      num_d[start_idx]  = NOTE_NUM;
      vel_d[start_idx]  = NOTE_VEL;
      gate_d[start_idx] = 1'b1;
      held_d[start_idx] = 1'b0;
      trig_d[start_idx] = 1'b1;
    end
    if (is_off && off_found) begin
      if (SUSTAIN) begin
        held_d[off_idx] = 1'b1;
      end else begin
        gate_d[off_idx] = 1'b0;
        vel_d[off_idx]  = '0;
      end
    end
    for (int i = 0; i < VOICES; i++) begin
      cnt_d = cnt_d + CNT_W'(gate_d[i]);
    end
  end

  // State registers; reset restores the age permutation age[i]=i
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < VOICES; i++) begin
        num_q[i] <= '0;
        vel_q[i] <= '0;
        age_q[i] <= AGE_W'(i);
      end
      gate_q    <= '0;
      held_q    <= '0;
      trig_q    <= '0;
      sus_q     <= 1'b0;
      stolen_q  <= 1'b0;
      dropped_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      num_q     <= num_d;
      vel_q     <= vel_d;
      age_q     <= age_d;
      gate_q    <= gate_d;
      held_q    <= held_d;
      trig_q    <= trig_d;
      sus_q     <= sus_d;
      stolen_q  <= stolen_d;
      dropped_q <= dropped_d;
      cnt_q     <= cnt_d;
    end
  end

  // Flatten per-voice registers onto the packed output buses
  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign VOICE_NUM[g*NUM_W +: NUM_W] = num_q[g];
    assign VOICE_VEL[g*VEL_W +: VEL_W] = vel_q[g];
  end

  assign VOICE_GATE = gate_q;
  assign VOICE_TRIG = trig_q;
  assign ACTIVE_CNT = cnt_q;
  assign STOLEN     = stolen_q;
  assign DROPPED    = dropped_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: two instances (stealing and dropping) share one
// directed stimulus stream; a behavioural model tracks both and is compared
// every cycle, with literal expectations pinning key points of the model.
module tb_voice_alloc;

  localparam int V  = 8;
  localparam int NW = 7;
  localparam int VW = 7;

  // Clock / reset / inputs
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic handle = 1'b0;
  logic note_on = 1'b0;
  logic note_off = 1'b0;
  logic sustain = 1'b0;
  logic [NW-1:0] note_num = '0;
  logic [VW-1:0] note_vel = '0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Outputs of the STEAL=1 instance (d1) and the STEAL=0 instance (d0)
  logic [V*NW-1:0] d1_num, d0_num;
  logic [V*VW-1:0] d1_vel, d0_vel;
  logic [V-1:0]    d1_gate, d0_gate, d1_trig, d0_trig;
  logic [3:0]      d1_cnt, d0_cnt;
  logic            d1_stolen, d0_stolen, d1_dropped, d0_dropped;

  voice_alloc #(.VOICES(V), .NUM_W(NW), .VEL_W(VW), .STEAL(1)) dut1 (
    .CLK(clk), .RST(rst_n), .CE(ce), .NOTE_NUM(note_num), .NOTE_VEL(note_vel),
    .HANDLE_NOTE(handle), .NOTE_ON(note_on), .NOTE_OFF(note_off), .SUSTAIN(sustain),
    .VOICE_NUM(d1_num), .VOICE_VEL(d1_vel), .VOICE_GATE(d1_gate), .VOICE_TRIG(d1_trig),
    .ACTIVE_CNT(d1_cnt), .STOLEN(d1_stolen), .DROPPED(d1_dropped)
  );

  voice_alloc #(.VOICES(V), .NUM_W(NW), .VEL_W(VW), .STEAL(0)) dut0 (
    .CLK(clk), .RST(rst_n), .CE(ce), .NOTE_NUM(note_num), .NOTE_VEL(note_vel),
    .HANDLE_NOTE(handle), .NOTE_ON(note_on), .NOTE_OFF(note_off), .SUSTAIN(sustain),
    .VOICE_NUM(d0_num), .VOICE_VEL(d0_vel), .VOICE_GATE(d0_gate), .VOICE_TRIG(d0_trig),
    .ACTIVE_CNT(d0_cnt), .STOLEN(d0_stolen), .DROPPED(d0_dropped)
  );

  // Behavioural model, index 0 = dropping instance, 1 = stealing instance.
  // Voice age is kept as a start timestamp: the oldest voice has the smallest.
  int m_num   [2][V];
  int m_vel   [2][V];
  int m_stamp [2][V];
  bit m_gate  [2][V];
  bit m_held  [2][V];
  bit m_trig  [2][V];
  bit m_stolen [2];
  bit m_dropped[2];
  bit m_sus    [2];
  int tick = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int s);
    int v;
    int f;
    bit rel;
    if (!rst_n) begin
      for (int i = 0; i < V; i++) begin
        m_num[s][i] = 0; m_vel[s][i] = 0; m_gate[s][i] = 0;
        m_held[s][i] = 0; m_trig[s][i] = 0; m_stamp[s][i] = -i;
      end
      m_stolen[s] = 0; m_dropped[s] = 0; m_sus[s] = 0;
      return;
    end
    for (int i = 0; i < V; i++) m_trig[s][i] = 0;
    m_stolen[s] = 0;
    m_dropped[s] = 0;
    if (!ce) return;
    rel = m_sus[s] && !sustain;
    m_sus[s] = sustain;
    v = -1;
    f = -1;
    // Decisions use the voice state from before this edge
    if (handle && (note_on || note_off)) begin
      if (note_on && !note_off && note_vel != 0) begin
        for (int i = 0; i < V; i++)
          if (v < 0 && m_gate[s][i] && m_num[s][i] == int'(note_num)) v = i;
        for (int i = 0; i < V; i++)
          if (v < 0 && !m_gate[s][i]) v = i;
        if (v < 0) begin
          if (s == 1) begin
            v = 0;
            for (int i = 1; i < V; i++)
              if (m_stamp[s][i] < m_stamp[s][v]) v = i;
            m_stolen[s] = 1;
          end else begin
            m_dropped[s] = 1;
          end
        end
      end else begin
        for (int i = 0; i < V; i++)
          if (f < 0 && m_gate[s][i] && !m_held[s][i] && m_num[s][i] == int'(note_num)) f = i;
      end
    end
    if (rel)
      for (int i = 0; i < V; i++)
        if (m_held[s][i]) begin
          m_gate[s][i] = 0; m_vel[s][i] = 0; m_held[s][i] = 0;
        end
    if (v >= 0) begin
      tick++;
      m_num[s][v] = int'(note_num); m_vel[s][v] = int'(note_vel);
      m_gate[s][v] = 1; m_held[s][v] = 0; m_trig[s][v] = 1; m_stamp[s][v] = tick;
    end
    if (f >= 0) begin
      if (sustain) m_held[s][f] = 1;
      else begin
        m_gate[s][f] = 0; m_vel[s][f] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic check_inst(input int s, input logic [V*NW-1:0] a_num, input logic [V*VW-1:0] a_vel,
                            input logic [V-1:0] a_gate, input logic [V-1:0] a_trig,
                            input logic [3:0] a_cnt, input logic a_stolen, input logic a_dropped);
    logic [V*NW-1:0] e_num;
    logic [V*VW-1:0] e_vel;
    logic [V-1:0]    e_gate;
    logic [V-1:0]    e_trig;
    int              e_cnt;
    e_cnt = 0;
    for (int i = 0; i < V; i++) begin
      e_num[i*NW +: NW] = NW'(m_num[s][i]);
      e_vel[i*VW +: VW] = VW'(m_vel[s][i]);
      e_gate[i] = m_gate[s][i];
      e_trig[i] = m_trig[s][i];
      if (m_gate[s][i]) e_cnt++;
    end
    cmp($sformatf("s%0d num", s), 64'(a_num), 64'(e_num));
    cmp($sformatf("s%0d vel", s), 64'(a_vel), 64'(e_vel));
    cmp($sformatf("s%0d gate", s), 64'(a_gate), 64'(e_gate));
    cmp($sformatf("s%0d trig", s), 64'(a_trig), 64'(e_trig));
    cmp($sformatf("s%0d cnt", s), 64'(a_cnt), 64'(e_cnt));
    cmp($sformatf("s%0d stolen", s), 64'(a_stolen), 64'(m_stolen[s]));
    cmp($sformatf("s%0d dropped", s), 64'(a_dropped), 64'(m_dropped[s]));
  endtask

  // Compare process: every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check_inst(1, d1_num, d1_vel, d1_gate, d1_trig, d1_cnt, d1_stolen, d1_dropped);
      check_inst(0, d0_num, d0_vel, d0_gate, d0_trig, d0_cnt, d0_stolen, d0_dropped);
    end
  end

  // Driver tasks: called just after a falling edge, return after the next one
  task automatic ev(input bit on, input bit off, input int num, input int vel);
    handle = 1'b1; note_on = on; note_off = off;
    note_num = NW'(num); note_vel = VW'(vel);
    @(negedge clk);
    handle = 1'b0; note_on = 1'b0; note_off = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    cmp("rst gate", 64'(d1_gate), 64'h0);
    cmp("rst cnt", 64'(d1_cnt), 64'h0);
    cmp("rst num", 64'(d1_num), 64'h0);
    rst_n = 1'b1;
    ce = 1'b1;

    // Fill all eight voices
    for (int i = 0; i < 8; i++) begin
      ev(1, 0, 60 + i, 100);
      cmp("fill trig", 64'(d1_trig), 64'(1) << i);
      cmp("fill stolen", 64'(d1_stolen), 64'h0);
    end
    cmp("full gate", 64'(d1_gate), 64'hFF);
    cmp("full cnt", 64'(d1_cnt), 64'd8);
    cmp("full num0", 64'(d1_num[6:0]), 64'd60);
    cmp("full num7", 64'(d1_num[55:49]), 64'd67);

    // Steal oldest (voice 0) vs drop
    ev(1, 0, 80, 50);
    cmp("steal num0", 64'(d1_num[6:0]), 64'd80);
    cmp("steal vel0", 64'(d1_vel[6:0]), 64'd50);
    cmp("steal pulse", 64'(d1_stolen), 64'h1);
    cmp("steal trig", 64'(d1_trig), 64'h1);
    cmp("steal gate", 64'(d1_gate), 64'hFF);
    cmp("drop pulse", 64'(d0_dropped), 64'h1);
    cmp("drop num0", 64'(d0_num[6:0]), 64'd60);
    cmp("drop trig", 64'(d0_trig), 64'h0);
    idle(1);
    cmp("steal one cycle", 64'(d1_stolen), 64'h0);
    cmp("drop one cycle", 64'(d0_dropped), 64'h0);
    ev(1, 0, 81, 50);
    cmp("steal2 num1", 64'(d1_num[13:7]), 64'd81);
    cmp("steal2 trig", 64'(d1_trig), 64'h2);
    // Retrigger while full, then the next steal must pick voice 2
    ev(1, 0, 80, 20);
    cmp("retrig trig", 64'(d1_trig), 64'h1);
    cmp("retrig stolen", 64'(d1_stolen), 64'h0);
    cmp("retrig vel0", 64'(d1_vel[6:0]), 64'd20);
    ev(1, 0, 82, 1);
    cmp("steal3 trig", 64'(d1_trig), 64'h4);

    // Velocity-0 note-off, unmatched off, on+off both set
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    ev(1, 0, 64, 90);
    ev(1, 0, 50, 30);
    cmp("two cnt", 64'(d1_cnt), 64'd2);
    ev(1, 0, 64, 0);
    cmp("vel0 gate", 64'(d1_gate), 64'h02);
    cmp("vel0 vel", 64'(d1_vel[6:0]), 64'h0);
    cmp("vel0 num kept", 64'(d1_num[6:0]), 64'd64);
    cmp("vel0 cnt", 64'(d1_cnt), 64'd1);
    ev(0, 1, 99, 0);
    cmp("nomatch gate", 64'(d1_gate), 64'h02);
    cmp("nomatch cnt", 64'(d1_cnt), 64'd1);
    ev(1, 1, 50, 30);
    cmp("both off gate", 64'(d1_gate), 64'h0);
    cmp("both off num", 64'(d1_num[13:7]), 64'd50);

    // Sustain hold, retrigger of a held voice, pedal release
    sustain = 1'b1;
    ev(1, 0, 62, 80);
    ev(0, 1, 62, 0);
    cmp("held gate", 64'(d1_gate), 64'h01);
    ev(1, 0, 62, 70);
    cmp("held retrig trig", 64'(d1_trig), 64'h1);
    cmp("held retrig vel", 64'(d1_vel[6:0]), 64'd70);
    ev(0, 1, 62, 0);
    cmp("held again gate", 64'(d1_gate), 64'h01);
    sustain = 1'b0;
    idle(1);
    cmp("pedal rel gate", 64'(d1_gate), 64'h0);
    cmp("pedal rel vel", 64'(d1_vel[6:0]), 64'h0);

    // Event on the pedal-release edge sees the held voice as busy
    sustain = 1'b1;
    ev(1, 0, 70, 60);
    ev(0, 1, 70, 0);
    ev(1, 0, 71, 60);
    sustain = 1'b0;
    ev(1, 0, 72, 60);
    cmp("rel+ev trig", 64'(d1_trig), 64'h04);
    cmp("rel+ev gate", 64'(d1_gate), 64'h06);
    cmp("rel+ev cnt", 64'(d1_cnt), 64'd2);

    // Clock enable low: event ignored, pulses cleared
    ce = 1'b0;
    ev(1, 0, 90, 10);
    cmp("ce0 gate", 64'(d1_gate), 64'h06);
    cmp("ce0 trig", 64'(d1_trig), 64'h0);
    cmp("ce0 num0", 64'(d1_num[6:0]), 64'd70);
    ce = 1'b1;
    ev(1, 0, 73, 5);
    ce = 1'b0;
    idle(1);
    cmp("ce0 pulse clr", 64'(d1_trig), 64'h0);
    cmp("ce0 gate hold", 64'(d1_gate), 64'h07);
    ce = 1'b1;

    // Reset right after an event, and an event lost on the reset edge
    ev(1, 0, 60, 100);
    rst_n = 1'b0;
    ev(1, 0, 61, 100);
    rst_n = 1'b1;
    cmp("mid rst gate", 64'(d1_gate), 64'h0);
    cmp("mid rst cnt", 64'(d1_cnt), 64'h0);
    cmp("mid rst vel", 64'(d1_vel), 64'h0);
    cmp("mid rst trig", 64'(d1_trig), 64'h0);
    for (int i = 0; i < 8; i++) ev(1, 0, 40 + i, 64);
    ev(1, 0, 90, 64);
    cmp("post rst steal", 64'(d1_trig), 64'h1);
    cmp("post rst stolen", 64'(d1_stolen), 64'h1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
